qbus_dma_arbiter: RTL and testbench
===================================

Name: qbus_dma_arbiter

Overview:
Shares the single QBUS DMA master interface between NREQ on-chip device controllers (RKV11, RLV12, …). Each controller keeps its own dma_read_req/dma_write_req handshake unchanged. The arbiter grants one controller at a time, round-robin, and steers address, data and status between the bus side and that controller. It sits between the device controllers and the QBUS DMA/bus-cycle engine.

Parameters:
NREQ, 2, number of requesting controllers (2..8)
ADDR_W, 22, bus address width (TAL)
DATA_W, 16, bus data width (TDL)

Ports:
clk  input  1  20MHz QBUS-domain clock
reset_n  input  1  asynchronous active-low reset
dev_read_req  input  NREQ  per-device DMA read request (memory→device)
dev_write_req  input  NREQ  per-device DMA write request (device→memory)
dev_tal  input  NREQ*ADDR_W  per-device address; device i occupies bits [i*ADDR_W +: ADDR_W]
dev_tdl  input  NREQ*DATA_W  per-device write data; same packing as dev_tal
dev_bus_master  output  NREQ  per-device copy of dma_bus_master; one-hot or zero
dev_complete  output  NREQ  per-device dma_complete pulse
dev_nxm  output  NREQ  per-device dma_nxm pulse
dma_read_req  output  1  to bus engine
dma_write_req  output  1  to bus engine
TAL  output  ADDR_W  address to bus engine
TDL  output  DATA_W  write data to bus engine; valid while granted and writing
dma_bus_master  input  1  from bus engine
dma_complete  input  1  from bus engine, 1-cycle pulse
dma_nxm  input  1  from bus engine, 1-cycle pulse
grant_id  output  3  index of current owner; 0 when idle
busy  output  1  a grant is outstanding

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; rr_ptr=0; all outputs 0, including TAL, TDL, grant_id and busy. Reset asserted mid-transfer drops dma_*_req immediately. No complete or nxm pulse is forwarded.
- Request vector: req[i] = dev_read_req[i] | dev_write_req[i].
- States:
  - IDLE: if any req, pick the first set req[i] scanning from rr_ptr upward modulo NREQ. Register owner=i and go to REQ. Otherwise stay.
  - REQ: dma_read_req=dev_read_req[owner], dma_write_req=dev_write_req[owner] (registered); busy=1. If both are set on the owner, read wins and write is masked. If the owner drops both requests before dma_bus_master, go to IDLE with rr_ptr unchanged. When dma_bus_master=1, go to XFER.
  - XFER: dev_bus_master[owner] follows dma_bus_master combinationally. On dma_complete or dma_nxm:
    - forward the pulse in the same cycle to dev_complete/dev_nxm[owner];
    - if both arrive together, forward both;
    - deassert dma_*_req next cycle;
    - rr_ptr = (owner+1) mod NREQ;
    - go to GAP.
  - GAP: one cycle with all requests low so the bus engine sees a release edge; busy=0; then IDLE.
- Latency: request seen at edge N → dma_*_req high after edge N+2. Minimum back-to-back spacing is 4 cycles plus bus time.
- TAL/TDL: combinational mux of dev_tal/dev_tdl[owner] while in REQ or XFER; 0 otherwise. The owner must hold TAL and TDL stable until its complete or nxm.
- dev_complete, dev_nxm and dev_bus_master for non-owners are always 0.
- A complete or nxm arriving outside XFER is ignored.
- A device raising its request while another owns the bus waits; it cannot be starved beyond NREQ-1 grants.
- Owner width: grant_id = owner zero-extended to 3 bits.

Optional Feature:
QSIC_DMA_BURST_EN.
- Defined: after a complete (not nxm), if the owner still requests and burst_cnt < 7, stay in REQ with the same owner and skip GAP/IDLE; burst_cnt increments.
  - burst_cnt resets to 0 on each new grant.
  - On the 8th transfer, or on nxm, the normal GAP/rr_ptr advance applies.
  - Required dma_*_req deassertion between burst words is one cycle (REQ re-entry), not GAP.
- Undefined: one word per grant as described above; burst_cnt is not present.

Test Plan:
- Reset, device 0 read request, TAL=22'o1000: dma_read_req rises 2 cycles later with TAL=22'o1000. Bench drives dma_bus_master then dma_complete → dev_complete[0] pulses for 1 cycle; grant_id=0; GAP seen.
- Devices 0 and 1 request continuously: grants alternate 0,1,0,1. dev_bus_master is never both high.
- Device 1 asserts read and write together, TDL=16'o123456: only dma_read_req is asserted; the write is masked.
- dma_nxm in XFER for device 1: dev_nxm[1]=1 for 1 cycle; dev_complete=0; next grant goes to device 0 if it is requesting.
- reset_n pulled low during XFER: all outputs 0 immediately. After release, rr_ptr=0 and device 0 wins a simultaneous 0/1 request.
- With QSIC_DMA_BURST_EN, device 0 requesting 10 words while device 1 is also requesting: device 0 gets 8 transfers, then device 1 is granted.

Source files
------------

// File: rtl/qbus_dma_arbiter_if.sv
// qbus_dma_arbiter_if
//   Bundles the device-controller side and the bus-engine side of the QBUS
//   DMA arbiter. Signal names match the original flat port list.
//   Device side : dev_read_req, dev_write_req, dev_tal, dev_tdl (to arbiter)
//                 dev_bus_master, dev_complete, dev_nxm         (from arbiter)
//   Engine side : dma_read_req, dma_write_req, TAL, TDL         (from arbiter)
//                 dma_bus_master, dma_complete, dma_nxm         (to arbiter)
//   Status      : grant_id (owner index, 0 when idle), busy
//   modport master : arbiter view; modport slave : environment view.
interface qbus_dma_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 16
);
  logic [NREQ-1:0]        dev_read_req;
  logic [NREQ-1:0]        dev_write_req;
  logic [NREQ*ADDR_W-1:0] dev_tal;
  logic [NREQ*DATA_W-1:0] dev_tdl;
  logic [NREQ-1:0]        dev_bus_master;
  logic [NREQ-1:0]        dev_complete;
  logic [NREQ-1:0]        dev_nxm;
  logic                   dma_read_req;
  logic                   dma_write_req;
  logic [ADDR_W-1:0]      TAL;
  logic [DATA_W-1:0]      TDL;
  logic                   dma_bus_master;
  logic                   dma_complete;
  logic                   dma_nxm;
  logic [2:0]             grant_id;
  logic                   busy;

  modport master (
    input  dev_read_req, dev_write_req, dev_tal, dev_tdl,
           dma_bus_master, dma_complete, dma_nxm,
    output dev_bus_master, dev_complete, dev_nxm,
           dma_read_req, dma_write_req, TAL, TDL, grant_id, busy
  );

  modport slave (
    output dev_read_req, dev_write_req, dev_tal, dev_tdl,
           dma_bus_master, dma_complete, dma_nxm,
    input  dev_bus_master, dev_complete, dev_nxm,
           dma_read_req, dma_write_req, TAL, TDL, grant_id, busy
  );
endinterface

// File: rtl/qbus_dma_arbiter.sv
// qbus_dma_arbiter
//   Shares one QBUS DMA master interface between NREQ device controllers.
//   Round-robin grant, one owner at a time; address/data/status are steered
//   between the bus engine and the owner.
//   Ports: clk (20 MHz QBUS clock), reset_n (async active-low),
//          bus (qbus_dma_arbiter_if.master, all handshake/bus signals).
//   Optional: define QSIC_DMA_BURST_EN to let an owner keep the bus for up to
//   8 consecutive completed words.
module qbus_dma_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  qbus_dma_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t            state, state_d;
  logic [2:0]        owner, owner_d;
  logic [2:0]        rr_ptr, rr_d, rr_step;
  logic              rd_r, wr_r, rd_d, wr_d;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   own_oh;
  logic              own_rd, own_wr;
  logic [ADDR_W-1:0] own_tal;
  logic [DATA_W-1:0] own_tdl;
  logic              any_req, hi_found;
  logic [2:0]        lo_pick, hi_pick, pick;
  logic              granted;
`ifdef QSIC_DMA_BURST_EN
  logic [2:0]        burst_cnt, burst_d;
`endif

  assign req = bus.dev_read_req | bus.dev_write_req;

  // Owner's request, address and data, selected by the registered owner.
  always_comb begin
    own_oh  = '0;
    own_rd  = 1'b0;
    own_wr  = 1'b0;
    own_tal = '0;
    own_tdl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == 3'(i)) begin
        own_oh[i] = 1'b1;
        own_rd    = bus.dev_read_req[i];
        own_wr    = bus.dev_write_req[i];
        own_tal   = bus.dev_tal[i*ADDR_W +: ADDR_W];
        own_tdl   = bus.dev_tdl[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotating priority as two scans: first requester at or above rr_ptr,
  // else the lowest requester overall (the wrapped part of the rotation).
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    lo_pick  = '0;
    hi_pick  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (!any_req) begin
          any_req = 1'b1;
          lo_pick = 3'(i);
        end
        if (!hi_found && (3'(i) >= rr_ptr)) begin
          hi_found = 1'b1;
          hi_pick  = 3'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  assign rr_step = (owner == 3'(NREQ-1)) ? 3'd0 : owner + 3'd1;

  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d    = rr_ptr;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
`ifdef QSIC_DMA_BURST_EN
    burst_d = burst_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_d = pick;
          state_d = REQ;
`ifdef QSIC_DMA_BURST_EN
          burst_d = '0;
`endif
        end
      end
      REQ: begin
        // Read has priority when the owner asks for both.
        rd_d = own_rd;
        wr_d = own_wr & ~own_rd;
        if (!(own_rd | own_wr)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if (bus.dma_bus_master && (rd_r | wr_r)) begin
          state_d = XFER;
        end
      end
      XFER: begin
        rd_d = rd_r;
        wr_d = wr_r;
        if (bus.dma_complete | bus.dma_nxm) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
`ifdef QSIC_DMA_BURST_EN
          // Re-entering REQ gives the single-cycle request drop the engine
          // needs between burst words.
          if (bus.dma_complete && !bus.dma_nxm && (own_rd | own_wr) &&
              (burst_cnt != 3'd7)) begin
            state_d = REQ;
            burst_d = burst_cnt + 3'd1;
          end else begin
            state_d = GAP;
            rr_d    = rr_step;
          end
`else
          state_d = GAP;
          rr_d    = rr_step;
`endif
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
`ifdef QSIC_DMA_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rr_ptr <= rr_d;
      rd_r   <= rd_d;
      wr_r   <= wr_d;
`ifdef QSIC_DMA_BURST_EN
      burst_cnt <= burst_d;
`endif
    end
  end

  assign granted            = (state == REQ) || (state == XFER);
  assign bus.busy           = granted;
  assign bus.grant_id       = granted ? owner : 3'd0;
  assign bus.dma_read_req   = rd_r;
  assign bus.dma_write_req  = wr_r;
  assign bus.TAL            = granted ? own_tal : '0;
  assign bus.TDL            = granted ? own_tdl : '0;
  assign bus.dev_bus_master = ((state == XFER) && bus.dma_bus_master) ? own_oh : '0;
  assign bus.dev_complete   = ((state == XFER) && bus.dma_complete) ? own_oh : '0;
  assign bus.dev_nxm        = ((state == XFER) && bus.dma_nxm) ? own_oh : '0;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// tb_qbus_dma_arbiter
//   Self-checking bench for qbus_dma_arbiter (NREQ=2). A table of single-device
//   transfers, plus hand-written sequences for contention, burst and reset.
//   Expected grants are queued when requests are driven and popped when the
//   arbiter raises its request to the bus engine.
module tb_qbus_dma_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 22;
  localparam int DW   = 16;

  typedef struct {
    logic [2:0]  gid;
    logic        rd;
    logic        wr;
    logic [21:0] tal;
    logic [15:0] tdl;
  } exp_t;

  typedef struct {
    int          dev;
    bit          rd;
    bit          wr;
    bit          nxm;
    logic [21:0] tal;
    logic [15:0] tdl;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   model_rr = 0;
  exp_t sb[$];
  vec_t vecs[6];

  qbus_dma_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus();

  qbus_dma_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #25 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input logic [2:0] i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic set_req(input int d, input bit rd, input bit wr,
                         input logic [21:0] tal, input logic [15:0] tdl);
    bus.dev_read_req[d]       = rd;
    bus.dev_write_req[d]      = wr;
    bus.dev_tal[d*AW +: AW]   = tal;
    bus.dev_tdl[d*DW +: DW]   = tdl;
  endtask

  task automatic wait_req(output bit seen, output int lat);
    seen = 0;
    lat  = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (bus.dma_read_req || bus.dma_write_req) seen = 1;
    end
  endtask

  // Acts as the bus engine for one word: waits for the request, compares it
  // with the queued expectation, grants, then completes (or nxm).
  task automatic serve(input bit nxm, input bit drop, input int exp_lat, input bit burst_next);
    exp_t e;
    bit   seen;
    int   lat;
    wait_req(seen, lat);
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) begin
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    e = sb.pop_front();
    chk("grant_id", 32'(bus.grant_id), 32'(e.gid));
    chk("dma_read_req", 32'(bus.dma_read_req), 32'(e.rd));
    chk("dma_write_req", 32'(bus.dma_write_req), 32'(e.wr));
    chk("TAL", 32'(bus.TAL), 32'(e.tal));
    chk("TDL", 32'(bus.TDL), 32'(e.tdl));
    chk("busy", 32'(bus.busy), 32'd1);
    bus.dma_bus_master = 1'b1;
    @(negedge clk);
    chk("dev_bus_master", 32'(bus.dev_bus_master), 32'(oh(e.gid)));
    if (nxm) bus.dma_nxm = 1'b1;
    else     bus.dma_complete = 1'b1;
    if (drop) set_req(int'(e.gid), 0, 0, '0, '0);
    #1;
    chk("dev_complete", 32'(bus.dev_complete), nxm ? 32'd0 : 32'(oh(e.gid)));
    chk("dev_nxm", 32'(bus.dev_nxm), nxm ? 32'(oh(e.gid)) : 32'd0);
    @(negedge clk);
    bus.dma_complete   = 1'b0;
    bus.dma_nxm        = 1'b0;
    bus.dma_bus_master = 1'b0;
    #1;
    chk("complete_pulse_len", 32'(bus.dev_complete | bus.dev_nxm), 32'd0);
    chk("req_released", 32'(bus.dma_read_req | bus.dma_write_req), 32'd0);
    if (burst_next) begin
      chk("burst_busy", 32'(bus.busy), 32'd1);
    end else begin
      chk("gap_busy", 32'(bus.busy), 32'd0);
      chk("gap_grant_id", 32'(bus.grant_id), 32'd0);
    end
  endtask

  initial begin
    bit   seen;
    int   lat;
    int   o;

    vecs[0] = '{dev:0, rd:1, wr:0, nxm:0, tal:22'o1000,    tdl:16'h0000};
    vecs[1] = '{dev:1, rd:1, wr:1, nxm:0, tal:22'o2000,    tdl:16'o123456};
    vecs[2] = '{dev:0, rd:0, wr:1, nxm:0, tal:22'o4000,    tdl:16'hA5A5};
    vecs[3] = '{dev:1, rd:1, wr:0, nxm:1, tal:22'o7777,    tdl:16'h0000};
    vecs[4] = '{dev:1, rd:0, wr:1, nxm:0, tal:22'h3FFFFF,  tdl:16'hFFFF};
    vecs[5] = '{dev:0, rd:1, wr:0, nxm:1, tal:22'o17,      tdl:16'h1234};

    bus.dev_read_req   = '0;
    bus.dev_write_req  = '0;
    bus.dev_tal        = '0;
    bus.dev_tdl        = '0;
    bus.dma_bus_master = 1'b0;
    bus.dma_complete   = 1'b0;
    bus.dma_nxm        = 1'b0;
    reset_n            = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_dma_req", 32'(bus.dma_read_req | bus.dma_write_req), 32'd0);
    chk("rst_TAL", 32'(bus.TAL), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single-device transfers from idle.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_req(vecs[v].dev, vecs[v].rd, vecs[v].wr, vecs[v].tal, vecs[v].tdl);
      sb.push_back('{gid:3'(vecs[v].dev), rd:vecs[v].rd, wr:(vecs[v].wr & !vecs[v].rd),
                     tal:vecs[v].tal, tdl:vecs[v].tdl});
      serve(vecs[v].nxm, 1, 2, 0);
      model_rr = (vecs[v].dev + 1) % NREQ;
    end

`ifndef QSIC_DMA_BURST_EN
    // Both devices request continuously: grants alternate; one nxm on device 1.
    @(negedge clk);
    set_req(0, 1, 0, 22'o1111, 16'h0);
    set_req(1, 1, 0, 22'o2222, 16'h0);
    for (int k = 0; k < 4; k++) begin
      o = model_rr;
      sb.push_back('{gid:3'(o), rd:1'b1, wr:1'b0, tal:(o == 0) ? 22'o1111 : 22'o2222, tdl:16'h0});
      serve(k == 2, 0, (k == 0) ? 2 : 3, 0);
      model_rr = (o + 1) % NREQ;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (4) @(negedge clk);
`else
    // Owner keeps requesting: 8 words in one grant, then the other device.
    @(negedge clk);
    set_req(0, 1, 0, 22'o1111, 16'h0);
    set_req(1, 1, 0, 22'o2222, 16'h0);
    o = model_rr;
    for (int w = 0; w < 8; w++) begin
      sb.push_back('{gid:3'(o), rd:1'b1, wr:1'b0, tal:(o == 0) ? 22'o1111 : 22'o2222, tdl:16'h0});
      serve(0, 0, (w == 0) ? 2 : 1, w < 7);
    end
    sb.push_back('{gid:3'(1 - o), rd:1'b1, wr:1'b0, tal:(o == 0) ? 22'o2222 : 22'o1111, tdl:16'h0});
    serve(0, 1, 3, 0);
    model_rr = o;
    set_req(o, 0, 0, '0, '0);
    repeat (4) @(negedge clk);
`endif

    // Leave rr_ptr at 1, then reset in the middle of a device-1 transfer.
    @(negedge clk);
    set_req(0, 1, 0, 22'o1000, 16'h0);
    sb.push_back('{gid:3'd0, rd:1'b1, wr:1'b0, tal:22'o1000, tdl:16'h0});
    serve(0, 1, 2, 0);
    @(negedge clk);
    set_req(1, 1, 0, 22'o3000, 16'h0007);
    wait_req(seen, lat);
    chk("rst_seq_req_seen", 32'(seen), 32'd1);
    bus.dma_complete = 1'b1;
    #1;
    chk("stray_complete", 32'(bus.dev_complete), 32'd0);
    @(negedge clk);
    bus.dma_complete = 1'b0;
    #1;
    chk("stray_hold_req", 32'(bus.dma_read_req), 32'd1);
    chk("rst_seq_gid", 32'(bus.grant_id), 32'd1);
    bus.dma_bus_master = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_seq_bm", 32'(bus.dev_bus_master), 32'(oh(3'd1)));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_dma_req", 32'(bus.dma_read_req | bus.dma_write_req), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("midrst_TAL", 32'(bus.TAL), 32'd0);
    chk("midrst_dev_bm", 32'(bus.dev_bus_master), 32'd0);
    @(negedge clk);
    bus.dma_bus_master = 1'b0;
    set_req(0, 1, 0, 22'o1000, 16'h0);
    reset_n = 1'b1;
    sb.push_back('{gid:3'd0, rd:1'b1, wr:1'b0, tal:22'o1000, tdl:16'h0});
    sb.push_back('{gid:3'd1, rd:1'b1, wr:1'b0, tal:22'o3000, tdl:16'h0007});
    serve(0, 1, 2, 0);
    serve(0, 1, 3, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
